// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage with branch redirect and wrong-path drop
// Fetches one word at a time from instruction memory, holds it for decode until it
// is accepted, and handles branch redirects that arrive while a request is in flight.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] instr_o,
  output logic [15:0] imm_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
);

  // FETCH: request outstanding for pc_q.
  // HOLD : instruction captured, waiting for decode to take it.
  // DROP : request for drop_addr_q still outstanding but its data is wrong-path.
  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;               // address of the next useful fetch
  logic [31:0] drop_addr_q, drop_addr_d; // address kept on the bus while draining a wrong-path request
  logic [31:0] instr_q, instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic        valid_q, valid_d;

  logic [31:0] branch_tgt;
  logic        ack_live;

  // Targets are forced to word alignment before they ever reach the pc.
  assign branch_tgt = branch_addr_i & ~32'h0000_0003;

  // The request stays up with a frozen address until the memory acks it.
  assign imem_req_o  = (state_q != ST_HOLD);
  assign imem_addr_o = (state_q == ST_DROP) ? drop_addr_q : pc_q;

  // An ack only means something while a request is actually being driven.
  assign ack_live = imem_req_o & imem_ack_i;

  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign imm_o      = instr_q[15:0];
  assign pc_o       = hold_pc_q;
  assign pc_plus4_o = hold_pc_q + 32'd4;

  // Next-state, pc and capture logic for the fetch/hold/drop sequence.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    instr_d     = instr_q;
    hold_pc_d   = hold_pc_q;

    case (state_q)
      ST_HOLD: begin
        // A branch wins over sequential advance even when decode also accepts.
        if (branch_i) begin
          pc_d    = branch_tgt;
          state_d = ST_FETCH;
        end else if (ready_i) begin
          pc_d    = pc_q + 32'd4;
          state_d = ST_FETCH;
        end
      end

      ST_DROP: begin
        // Keep tracking the newest redirect while the stale request drains.
        if (branch_i) begin
          pc_d = branch_tgt;
        end
        if (ack_live) begin
          state_d = ST_FETCH;
        end
      end

      default: begin
        if (branch_i) begin
          pc_d = branch_tgt;
          // Without an ack the old request is still open and must be drained;
          // with an ack it closes now, so the data is simply not captured.
          if (!ack_live) begin
            drop_addr_d = pc_q;
            state_d     = ST_DROP;
          end else begin
            state_d     = ST_FETCH;
          end
        end else if (ack_live) begin
          instr_d   = imem_data_i;
          hold_pc_d = pc_q;
          state_d   = ST_HOLD;
        end else begin
          state_d   = ST_FETCH;
        end
      end
    endcase

    valid_d = (state_d == ST_HOLD);
  end

  // State and datapath registers; reset overrides any ack or branch in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      drop_addr_q <= 32'h0000_0000;
      instr_q     <= 32'h0000_0000;
      hold_pc_q   <= 32'h0000_0000;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      instr_q     <= instr_d;
      hold_pc_q   <= hold_pc_d;
      valid_q     <= valid_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        br;
  logic [31:0] br_addr;
  logic        ack;
  logic [31:0] data;
  logic        rdy;
  logic        req;
  logic [31:0] addr;
  logic        vld;
  logic [31:0] instr;
  logic [15:0] imm;
  logic [31:0] pc;
  logic [31:0] pc4;

  logic        w_rst;
  logic        w_br;
  logic [31:0] w_br_addr;
  logic        w_ack;
  logic [31:0] w_data;
  logic        w_rdy;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_vld;
  logic [31:0] w_instr;
  logic [15:0] w_imm;
  logic [31:0] w_pc;
  logic [31:0] w_pc4;

  int checks;
  int failures;

  instr_fetch dut (
    .clk_i(clk), .rst_i(rst), .branch_i(br), .branch_addr_i(br_addr),
    .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack), .imem_data_i(data),
    .valid_o(vld), .ready_i(rdy), .instr_o(instr), .imm_o(imm),
    .pc_o(pc), .pc_plus4_o(pc4)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk_i(clk), .rst_i(w_rst), .branch_i(w_br), .branch_addr_i(w_br_addr),
    .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_ack_i(w_ack), .imem_data_i(w_data),
    .valid_o(w_vld), .ready_i(w_rdy), .instr_o(w_instr), .imm_o(w_imm),
    .pc_o(w_pc), .pc_plus4_o(w_pc4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        br;
    logic [31:0] tgt;
    logic        ack;
    logic [31:0] data;
    logic        rdy;
    logic        chk;
    logic        chkd;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] instr;
    logic [31:0] pc;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic b, input logic [31:0] t,
                              input logic a, input logic [31:0] d, input logic y,
                              input logic c, input logic cd, input logic q,
                              input logic [31:0] ad, input logic v,
                              input logic [31:0] ins, input logic [31:0] p);
    vec_t x;
    x.rst = r; x.br = b; x.tgt = t; x.ack = a; x.data = d; x.rdy = y;
    x.chk = c; x.chkd = cd; x.req = q; x.addr = ad; x.vld = v; x.instr = ins; x.pc = p;
    return x;
  endfunction

  vec_t vecs[29];

  // Reference model state: what the fetch unit is holding / where it will fetch next.
  logic        m_valid;
  logic        m_stale;
  logic [31:0] m_pc;
  logic [31:0] m_stale_addr;
  logic [31:0] m_instr;
  logic [31:0] m_hpc;

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1; br = 1'b0; br_addr = '0; ack = 1'b0; data = '0; rdy = 1'b0;
    w_rst = 1'b1; w_br = 1'b0; w_br_addr = '0; w_ack = 1'b0; w_data = '0; w_rdy = 1'b0;

    //               rst br tgt          ack data          rdy  chk chkd req addr         vld instr         pc
    vecs[0]  = mk(1, 0, 32'h0,     0, 32'h0,         0,   0, 0, 0, 32'h0,   0, 32'h0,         32'h0);
    vecs[1]  = mk(0, 0, 32'h0,     1, 32'h2009_FFFF, 1,   1, 1, 1, 32'h0,   0, 32'h0,         32'h0);
    vecs[2]  = mk(0, 0, 32'h0,     0, 32'h0,         1,   1, 1, 0, 32'h0,   1, 32'h2009_FFFF, 32'h0);
    vecs[3]  = mk(0, 0, 32'h0,     1, 32'h1234_5678, 0,   1, 0, 1, 32'h4,   0, 32'h0,         32'h0);
    vecs[4]  = mk(0, 0, 32'h0,     0, 32'h0,         0,   1, 1, 0, 32'h0,   1, 32'h1234_5678, 32'h4);
    vecs[5]  = mk(0, 0, 32'h0,     1, 32'hDEAD_BEEF, 0,   1, 1, 0, 32'h0,   1, 32'h1234_5678, 32'h4);
    vecs[6]  = mk(0, 0, 32'h0,     1, 32'hDEAD_BEEF, 0,   1, 1, 0, 32'h0,   1, 32'h1234_5678, 32'h4);
    vecs[7]  = mk(0, 0, 32'h0,     1, 32'hDEAD_BEEF, 0,   1, 1, 0, 32'h0,   1, 32'h1234_5678, 32'h4);
    vecs[8]  = mk(0, 0, 32'h0,     1, 32'hDEAD_BEEF, 0,   1, 1, 0, 32'h0,   1, 32'h1234_5678, 32'h4);
    vecs[9]  = mk(0, 0, 32'h0,     0, 32'h0,         1,   1, 1, 0, 32'h0,   1, 32'h1234_5678, 32'h4);
    vecs[10] = mk(0, 0, 32'h0,     1, 32'h0000_000A, 1,   1, 0, 1, 32'h8,   0, 32'h0,         32'h0);
    vecs[11] = mk(0, 0, 32'h0,     0, 32'h0,         1,   1, 1, 0, 32'h0,   1, 32'h0000_000A, 32'h8);
    vecs[12] = mk(0, 0, 32'h0,     1, 32'h0000_000B, 1,   1, 0, 1, 32'hC,   0, 32'h0,         32'h0);
    vecs[13] = mk(0, 0, 32'h0,     0, 32'h0,         1,   1, 1, 0, 32'h0,   1, 32'h0000_000B, 32'hC);
    vecs[14] = mk(0, 1, 32'h43,    0, 32'h0,         0,   1, 0, 1, 32'h10,  0, 32'h0,         32'h0);
    vecs[15] = mk(0, 0, 32'h0,     0, 32'h0,         0,   1, 0, 1, 32'h10,  0, 32'h0,         32'h0);
    vecs[16] = mk(0, 0, 32'h0,     1, 32'hFFFF_0000, 1,   1, 0, 1, 32'h10,  0, 32'h0,         32'h0);
    vecs[17] = mk(0, 0, 32'h0,     1, 32'hC0DE_0040, 0,   1, 0, 1, 32'h40,  0, 32'h0,         32'h0);
    vecs[18] = mk(0, 0, 32'h0,     0, 32'h0,         1,   1, 1, 0, 32'h0,   1, 32'hC0DE_0040, 32'h40);
    vecs[19] = mk(0, 1, 32'h22,    1, 32'hBADB_AD00, 0,   1, 0, 1, 32'h44,  0, 32'h0,         32'h0);
    vecs[20] = mk(0, 0, 32'h0,     1, 32'hAAAA_5555, 0,   1, 0, 1, 32'h20,  0, 32'h0,         32'h0);
    vecs[21] = mk(0, 1, 32'h80,    0, 32'h0,         1,   1, 1, 0, 32'h0,   1, 32'hAAAA_5555, 32'h20);
    vecs[22] = mk(0, 1, 32'h100,   0, 32'h0,         0,   1, 0, 1, 32'h80,  0, 32'h0,         32'h0);
    vecs[23] = mk(0, 1, 32'h201,   0, 32'h0,         0,   1, 0, 1, 32'h80,  0, 32'h0,         32'h0);
    vecs[24] = mk(0, 0, 32'h0,     0, 32'h0,         0,   1, 0, 1, 32'h80,  0, 32'h0,         32'h0);
    vecs[25] = mk(0, 0, 32'h0,     1, 32'h1111_1111, 0,   1, 0, 1, 32'h80,  0, 32'h0,         32'h0);
    vecs[26] = mk(0, 1, 32'h300,   0, 32'h0,         0,   1, 0, 1, 32'h200, 0, 32'h0,         32'h0);
    vecs[27] = mk(1, 0, 32'h0,     1, 32'h0000_0055, 1,   1, 0, 1, 32'h200, 0, 32'h0,         32'h0);
    vecs[28] = mk(0, 0, 32'h0,     0, 32'h0,         0,   1, 1, 1, 32'h0,   0, 32'h0,         32'h0);

    // Directed vectors: inputs applied after an edge, outputs checked mid-cycle.
    for (int i = 0; i < 29; i++) begin
      rst = vecs[i].rst; br = vecs[i].br; br_addr = vecs[i].tgt;
      ack = vecs[i].ack; data = vecs[i].data; rdy = vecs[i].rdy;
      #4;
      if (vecs[i].chk) begin
        check($sformatf("v%0d_req", i), {31'b0, req}, {31'b0, vecs[i].req});
        if (vecs[i].req) check($sformatf("v%0d_addr", i), addr, vecs[i].addr);
        check($sformatf("v%0d_valid", i), {31'b0, vld}, {31'b0, vecs[i].vld});
        if (vecs[i].chkd) begin
          check($sformatf("v%0d_instr", i), instr, vecs[i].instr);
          check($sformatf("v%0d_imm", i), {16'b0, imm}, {16'b0, vecs[i].instr[15:0]});
          check($sformatf("v%0d_pc", i), pc, vecs[i].pc);
          check($sformatf("v%0d_pc4", i), pc4, vecs[i].pc + 32'd4);
        end
      end
      @(posedge clk); #1;
    end

    // Randomized traffic against the reference model.
    m_valid = 1'b0; m_stale = 1'b0; m_pc = '0; m_stale_addr = '0; m_instr = '0; m_hpc = '0;
    for (int c = 0; c < 3000; c++) begin
      rst     = (c == 0) || ($urandom_range(0, 63) == 0);
      br      = ($urandom_range(0, 7) == 0);
      br_addr = $urandom;
      ack     = $urandom_range(0, 1) == 1;
      data    = $urandom;
      rdy     = $urandom_range(0, 1) == 1;
      #4;
      if (c != 0) begin
        check("rnd_req", {31'b0, req}, {31'b0, !m_valid});
        if (!m_valid) check("rnd_addr", addr, m_stale ? m_stale_addr : m_pc);
        check("rnd_valid", {31'b0, vld}, {31'b0, m_valid});
        if (m_valid) begin
          check("rnd_instr", instr, m_instr);
          check("rnd_imm", {16'b0, imm}, {16'b0, m_instr[15:0]});
          check("rnd_pc", pc, m_hpc);
          check("rnd_pc4", pc4, m_hpc + 32'd4);
        end
      end
      if (rst) begin
        m_valid = 1'b0; m_stale = 1'b0; m_pc = 32'h0; m_instr = '0; m_hpc = '0;
      end else if (m_valid) begin
        if (br) begin
          m_pc = br_addr & ~32'h3; m_valid = 1'b0;
        end else if (rdy) begin
          m_pc = m_pc + 32'd4; m_valid = 1'b0;
        end
      end else if (m_stale) begin
        if (br) m_pc = br_addr & ~32'h3;
        if (ack) m_stale = 1'b0;
      end else begin
        if (br) begin
          if (!ack) begin
            m_stale = 1'b1; m_stale_addr = m_pc;
          end
          m_pc = br_addr & ~32'h3;
        end else if (ack) begin
          m_valid = 1'b1; m_instr = data; m_hpc = m_pc;
        end
      end
      @(posedge clk); #1;
    end
    rst = 1'b0; br = 1'b0; ack = 1'b0; rdy = 1'b0;

    // Wrap of the sequential pc from the top word back to zero.
    w_rst = 1'b0; w_ack = 1'b1; w_data = 32'h0000_1234; w_rdy = 1'b1;
    #4;
    check("wrap_req0", {31'b0, w_req}, 32'h1);
    check("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    check("wrap_valid0", {31'b0, w_vld}, 32'h0);
    @(posedge clk); #1;
    w_ack = 1'b0;
    #4;
    check("wrap_valid1", {31'b0, w_vld}, 32'h1);
    check("wrap_pc1", w_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", w_pc4, 32'h0);
    check("wrap_imm1", {16'b0, w_imm}, 32'h0000_1234);
    @(posedge clk); #1;
    w_rdy = 1'b0;
    #4;
    check("wrap_req2", {31'b0, w_req}, 32'h1);
    check("wrap_addr2", w_addr, 32'h0);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
